mmcm_lock_seq: RTL and testbench
================================

# mmcm_lock_seq

Reset-and-lock sequencer for the board clock manager that derives the 24 MHz camera clock and 25 MHz VGA clock from the 100 MHz board clock. It runs on the 100 MHz input clock and drives the MMCM reset. It monitors the asynchronous MMCM lock flag, qualifies lock stability, and retries with a timeout when lock fails. It releases a single system reset request to downstream logic only after a stable lock, and re-sequences on loss of lock.

## Interface
- RST_HOLD_CYC, 16: cycles MMCM_RST is held high per attempt (≥2).
- LOCK_TIMEOUT_CYC, 100000: cycles to wait for lock before a retry (1 ms at 100 MHz).
- LOCK_STABLE_CYC, 1024: cycles lock must stay continuously high before release.
- MAX_RETRIES, 3: timeouts tolerated before FAULT (1..3).
- CNT_W, 17: shared counter width. Must hold max(all *_CYC)-1; width violation is an elaboration error.

- CLK_IN1  in  1  100 MHz board clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high; deassertion externally synchronized.
- MMCM_LOCKED  in  1  LOCKED from clock manager; asynchronous, synchronized internally (2 flops).
- RETRY_CLR  in  1  single-cycle pulse; restarts sequence from FAULT only.
- MMCM_RST  out  1  reset to clock manager, active-high.
- SYS_RST  out  1  downstream reset request, active-high (re-synchronized in each consumer domain).
- READY  out  1  high only in RUN.
- FAULT  out  1  high only in FAULT.
- RETRY_CNT  out  2  timeouts in the current attempt series.
- LOSS_CNT  out  8  lock losses seen in RUN, saturating at 255.
- STATE  out  3  current state encoding.

## Operation
- States/encoding: RST_HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4. Other codes go to RST_HOLD next cycle.
- Reset applies asynchronously: STATE=RST_HOLD, cnt=0, RETRY_CNT=0, LOSS_CNT=0, sync flops=0, MMCM_RST=1, SYS_RST=1, READY=0, FAULT=0.
- All outputs are registers loaded with the decode of the next state, so they change on the same edge as STATE.
- RST_HOLD: MMCM_RST=1. cnt increments. At cnt==RST_HOLD_CYC-1, go to WAIT_LOCK with cnt=0.
- WAIT_LOCK: MMCM_RST=0.
  - locked_s=1: go to STABLE, cnt=0.
  - Else at cnt==LOCK_TIMEOUT_CYC-1: if RETRY_CNT==MAX_RETRIES, go to FAULT. Otherwise RETRY_CNT+1, go to RST_HOLD, cnt=0.
- STABLE: MMCM_RST=0.
  - locked_s=0: return to WAIT_LOCK with cnt=0. Timeout restarts; RETRY_CNT unchanged.
  - At cnt==LOCK_STABLE_CYC-1 with locked_s=1: go to RUN, RETRY_CNT=0.
- RUN: SYS_RST=0, READY=1. locked_s=0 goes to RST_HOLD with cnt=0 and LOSS_CNT+1 (saturating). SYS_RST reasserts on that same edge.
- FAULT: MMCM_RST=1, SYS_RST=1, FAULT=1. Holds indefinitely. RETRY_CLR=1 goes to RST_HOLD with RETRY_CNT=0 and cnt=0; LOSS_CNT is kept.
- SYS_RST=1 and READY=0 in every state except RUN.
- RETRY_CLR is ignored outside FAULT.
- Lock loss in the same cycle as a timeout or stable-count terminal: lock status has priority. A terminal count without lock never reaches RUN.

## Timing
- Power-up: MMCM_RST stays high RST_HOLD_CYC cycles after the first edge with RESET low. It falls on the edge entering WAIT_LOCK.
- Lock input to state: a MMCM_LOCKED rise reaches locked_s 2 edges later; STABLE is entered on the next edge.
- Lock to READY: READY/SYS_RST release occurs LOCK_STABLE_CYC edges after STABLE entry. That is 3+LOCK_STABLE_CYC edges after the sampled LOCKED rise (+1 for synchronizer uncertainty).
- Lock loss in RUN: SYS_RST rises and READY falls 3 edges after the LOCKED fall. MMCM_RST rises on the same edge.
- Worst-case time to FAULT: (MAX_RETRIES+1)×(RST_HOLD_CYC+LOCK_TIMEOUT_CYC) cycles.
- RESET mid-operation: all outputs take reset values immediately (asynchronous), then the full sequence restarts.

## Test plan
(Parameters RST_HOLD_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, MAX_RETRIES=2.)
- Nominal bring-up: RESET released, LOCKED rises 10 cycles after MMCM_RST falls. Expect MMCM_RST high exactly 4 cycles, STATE 0→1→2→3, READY high 11 edges after LOCKED rise, RETRY_CNT=0.
- Lock never arrives: expect 3 WAIT_LOCK timeouts of 20 cycles and RETRY_CNT 0→1→2, then FAULT=1 with MMCM_RST=1. Then pulse RETRY_CLR, assert LOCKED, and expect RUN with LOSS_CNT unchanged.
- Glitchy lock: LOCKED high 5 cycles, low 1, high again. Expect STABLE→WAIT_LOCK→STABLE, READY only after 8 continuous locked_s cycles, RETRY_CNT unchanged.
- Lock loss in RUN: drop LOCKED for 1 cycle. Expect SYS_RST=1 and MMCM_RST=1 3 edges later, LOSS_CNT=1, full resequence to RUN. Repeat 300 times and expect LOSS_CNT=255.
- Async reset mid-STABLE: RESET pulse between clock edges. Expect outputs at reset values before the next edge and STATE=0.
- RETRY_CLR pulsed in RUN and WAIT_LOCK: expect no state or counter change.

Source files
------------

// File: rtl/mmcm_lock_seq_if.sv
// Control/status bundle between the MMCM lock sequencer and the clock-manager wrapper:
// asynchronous lock flag and retry request in, reset requests and status out.
interface mmcm_lock_seq_if;
    logic       MMCM_LOCKED;
    logic       RETRY_CLR;
    logic       MMCM_RST;
    logic       SYS_RST;
    logic       READY;
    logic       FAULT;
    logic [1:0] RETRY_CNT;
    logic [7:0] LOSS_CNT;
    logic [2:0] STATE;

    modport master (
        input  MMCM_LOCKED, RETRY_CLR,
        output MMCM_RST, SYS_RST, READY, FAULT, RETRY_CNT, LOSS_CNT, STATE
    );

    modport slave (
        output MMCM_LOCKED, RETRY_CLR,
        input  MMCM_RST, SYS_RST, READY, FAULT, RETRY_CNT, LOSS_CNT, STATE
    );
endinterface

// File: rtl/mmcm_lock_seq.sv
// MMCM reset-and-lock sequencer: holds the MMCM in reset, waits for a stable lock with
// timeout/retry, then releases the system reset; any lock loss re-runs the sequence.
module mmcm_lock_seq #(
    parameter int RST_HOLD_CYC     = 16,
    parameter int LOCK_TIMEOUT_CYC = 100000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRIES      = 3,
    parameter int CNT_W            = 17
) (
    input  logic           CLK_IN1,
    input  logic           RESET,
    mmcm_lock_seq_if.master bus
);

    localparam longint CNT_SPAN = 64'd1 << CNT_W;

    generate
        if (RST_HOLD_CYC < 2 || LOCK_TIMEOUT_CYC < 1 || LOCK_STABLE_CYC < 1 ||
            MAX_RETRIES < 1 || MAX_RETRIES > 3 ||
            longint'(RST_HOLD_CYC) > CNT_SPAN ||
            longint'(LOCK_TIMEOUT_CYC) > CNT_SPAN ||
            longint'(LOCK_STABLE_CYC) > CNT_SPAN) begin : g_bad_params
            $error("mmcm_lock_seq: cycle parameter out of range or CNT_W too narrow");
        end
    endgenerate

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RST_HOLD  = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             lock_sync_p0, lock_sync_p1;
    logic             locked_s;
    logic             mmcm_rst_q, sys_rst_q, ready_q, fault_q;
    logic             mmcm_rst_d, sys_rst_d, ready_d, fault_d;

    assign locked_s = lock_sync_p1;

    // Stage boundary: asynchronous MMCM_LOCKED -> two-flop synchronizer -> FSM.
    always_ff @(posedge CLK_IN1 or posedge RESET) begin
        if (RESET) begin
            lock_sync_p0 <= 1'b0;
            lock_sync_p1 <= 1'b0;
            state_q      <= S_RST_HOLD;
            cnt_q        <= '0;
            retry_q      <= '0;
            loss_q       <= '0;
            mmcm_rst_q   <= 1'b1;
            sys_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            lock_sync_p0 <= bus.MMCM_LOCKED;
            lock_sync_p1 <= lock_sync_p0;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            mmcm_rst_q   <= mmcm_rst_d;
            sys_rst_q    <= sys_rst_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    // Lock status is tested before any terminal count so a count never wins over a lost lock.
    always_comb begin
        state_d = S_RST_HOLD;
        cnt_d   = '0;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            S_RST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT_LOCK;
                end else begin
                    state_d = S_RST_HOLD;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_RST_HOLD;
                        retry_d = retry_q + 2'd1;
                    end
                end else begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end else begin
                    state_d = S_STABLE;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d = S_RST_HOLD;
                    loss_d  = sat_inc8(loss_q);
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FAULT: begin
                if (bus.RETRY_CLR) begin
                    state_d = S_RST_HOLD;
                    retry_d = '0;
                end else begin
                    state_d = S_FAULT;
                end
            end
            default: state_d = S_RST_HOLD;
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same edge as STATE.
    always_comb begin
        mmcm_rst_d = 1'b0;
        sys_rst_d  = 1'b1;
        ready_d    = 1'b0;
        fault_d    = 1'b0;
        case (state_d)
            S_RST_HOLD: mmcm_rst_d = 1'b1;
            S_RUN: begin
                sys_rst_d = 1'b0;
                ready_d   = 1'b1;
            end
            S_FAULT: begin
                mmcm_rst_d = 1'b1;
                fault_d    = 1'b1;
            end
            default: mmcm_rst_d = 1'b0;
        endcase
    end

    assign bus.MMCM_RST  = mmcm_rst_q;
    assign bus.SYS_RST   = sys_rst_q;
    assign bus.READY     = ready_q;
    assign bus.FAULT     = fault_q;
    assign bus.RETRY_CNT = retry_q;
    assign bus.LOSS_CNT  = loss_q;
    assign bus.STATE     = state_q;

endmodule

// File: tb/tb_mmcm_lock_seq.sv
// Bench for mmcm_lock_seq: directed lock/unlock stimulus pushes expected output transitions
// (with dwell in clock edges) into a queue; a monitor pops one per observed output change.
module tb_mmcm_lock_seq;

    logic clk = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    typedef struct {
        logic [16:0] tup;
        int          dwell;
        string       name;
    } exp_t;

    exp_t sb[$];

    mmcm_lock_seq_if bus ();

    mmcm_lock_seq #(
        .RST_HOLD_CYC    (4),
        .LOCK_TIMEOUT_CYC(20),
        .LOCK_STABLE_CYC (8),
        .MAX_RETRIES     (2),
        .CNT_W           (8)
    ) dut (
        .CLK_IN1(clk),
        .RESET  (RESET),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!RESET) edge_cnt <= edge_cnt + 1;

    function automatic logic [16:0] snap();
        return {bus.STATE, bus.MMCM_RST, bus.SYS_RST, bus.READY, bus.FAULT,
                bus.RETRY_CNT, bus.LOSS_CNT};
    endfunction

    // Expected output tuple for a state, from the state's documented output levels.
    function automatic logic [16:0] tup(input logic [2:0] st, input logic [1:0] rc,
                                        input logic [7:0] lc);
        logic m, s, r, f;
        m = (st == 3'd0) || (st == 3'd4);
        s = (st != 3'd3);
        r = (st == 3'd3);
        f = (st == 3'd4);
        return {st, m, s, r, f, rc, lc};
    endfunction

    function automatic void expect_tr(input logic [2:0] st, input logic [1:0] rc,
                                      input logic [7:0] lc, input int dwell, input string nm);
        exp_t e;
        e.tup   = tup(st, rc, lc);
        e.dwell = dwell;
        e.name  = nm;
        sb.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, got, req);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
        int n;
        n = 0;
        checks++;
        do begin
            @(negedge clk);
            n++;
        end while (bus.STATE !== s && n < budget);
        if (bus.STATE !== s) begin
            errors++;
            $display("FAIL %s: STATE=%0d after %0d cycles, required %0d", nm, bus.STATE, n, s);
        end
    endtask

    task automatic wait_leave(input logic [2:0] s, input int budget, input string nm);
        int n;
        n = 0;
        checks++;
        do begin
            @(negedge clk);
            n++;
        end while (bus.STATE === s && n < budget);
        if (bus.STATE === s) begin
            errors++;
            $display("FAIL %s: STATE still %0d after %0d cycles, required a change", nm, s, n);
        end
    endtask

    task automatic run_monitor();
        logic [16:0] cur, prev;
        int          last, dw;
        exp_t        e;
        prev = '0;
        last = 0;
        forever begin
            @(negedge clk);
            cur = snap();
            if (RESET) begin
                prev = cur;
                last = edge_cnt;
            end else if (cur !== prev) begin
                dw = edge_cnt - last;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got tuple=%h dwell=%0d, required no change",
                             cur, dw);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e.tup || (e.dwell >= 0 && dw != e.dwell)) begin
                        errors++;
                        $display("FAIL %s: got state=%0d retry=%0d loss=%0d tuple=%h dwell=%0d, required tuple=%h dwell=%0d",
                                 e.name, cur[16:14], cur[9:8], cur[7:0], cur, dw, e.tup, e.dwell);
                    end
                end
                prev = cur;
                last = edge_cnt;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lc;
        RESET = 1'b1;
        bus.MMCM_LOCKED = 1'b0;
        bus.RETRY_CLR   = 1'b0;
        fork
            run_monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 chk("reset_tuple", 32'(snap()), 32'(tup(3'd0, 2'd0, 8'd0)));

        // Nominal bring-up: LOCKED rises 9.5 cycles into WAIT_LOCK.
        expect_tr(3'd1, 2'd0, 8'd0, 4, "A_hold_to_wait");
        @(posedge clk); #2 RESET = 1'b0;
        wait_state(3'd1, 20, "A_reach_wait");
        repeat (9) @(negedge clk);
        expect_tr(3'd2, 2'd0, 8'd0, 12, "A_wait_to_stable");
        expect_tr(3'd3, 2'd0, 8'd0, 8, "A_stable_to_run");
        bus.MMCM_LOCKED = 1'b1;
        wait_state(3'd3, 40, "A_reach_run");

        // RETRY_CLR in RUN has no effect.
        repeat (3) @(negedge clk);
        bus.RETRY_CLR = 1'b1;
        @(negedge clk);
        bus.RETRY_CLR = 1'b0;
        repeat (5) @(negedge clk);
        chk("B_run_state", 32'(bus.STATE), 32'd3);
        chk("B_run_ready", 32'(bus.READY), 32'd1);
        chk("B_run_loss", 32'(bus.LOSS_CNT), 32'd0);

        // Lock lost and never returns: three timeouts then FAULT.
        expect_tr(3'd0, 2'd0, 8'd1, -1, "C_loss");
        expect_tr(3'd1, 2'd0, 8'd1, 4, "C_wait0");
        expect_tr(3'd0, 2'd1, 8'd1, 20, "C_timeout0");
        expect_tr(3'd1, 2'd1, 8'd1, 4, "C_wait1");
        expect_tr(3'd0, 2'd2, 8'd1, 20, "C_timeout1");
        expect_tr(3'd1, 2'd2, 8'd1, 4, "C_wait2");
        expect_tr(3'd4, 2'd2, 8'd1, 20, "C_fault");
        bus.MMCM_LOCKED = 1'b0;
        wait_state(3'd4, 200, "C_reach_fault");
        repeat (10) @(negedge clk);
        chk("C_fault_hold", 32'(bus.FAULT), 32'd1);
        chk("C_fault_mmcm_rst", 32'(bus.MMCM_RST), 32'd1);
        expect_tr(3'd0, 2'd0, 8'd1, -1, "C_clr_hold");
        expect_tr(3'd1, 2'd0, 8'd1, 4, "C_clr_wait");
        expect_tr(3'd2, 2'd0, 8'd1, 1, "C_clr_stable");
        expect_tr(3'd3, 2'd0, 8'd1, 8, "C_clr_run");
        bus.RETRY_CLR   = 1'b1;
        bus.MMCM_LOCKED = 1'b1;
        @(negedge clk);
        bus.RETRY_CLR = 1'b0;
        wait_state(3'd3, 40, "C_reach_run");
        chk("C_loss_kept", 32'(bus.LOSS_CNT), 32'd1);

        // Glitchy lock, with RETRY_CLR pulsed in WAIT_LOCK.
        expect_tr(3'd0, 2'd0, 8'd2, -1, "D_loss");
        expect_tr(3'd1, 2'd0, 8'd2, 4, "D_wait");
        bus.MMCM_LOCKED = 1'b0;
        wait_state(3'd1, 40, "D_reach_wait");
        bus.RETRY_CLR = 1'b1;
        @(negedge clk);
        bus.RETRY_CLR = 1'b0;
        @(negedge clk);
        expect_tr(3'd2, 2'd0, 8'd2, 5, "D_stable1");
        expect_tr(3'd1, 2'd0, 8'd2, 5, "D_glitch_drop");
        expect_tr(3'd2, 2'd0, 8'd2, 1, "D_stable2");
        expect_tr(3'd3, 2'd0, 8'd2, 8, "D_run");
        bus.MMCM_LOCKED = 1'b1;
        repeat (5) @(negedge clk);
        bus.MMCM_LOCKED = 1'b0;
        @(negedge clk);
        bus.MMCM_LOCKED = 1'b1;
        wait_state(3'd3, 40, "D_reach_run");
        chk("D_retry_cnt", 32'(bus.RETRY_CNT), 32'd0);

        // One-cycle lock drops in RUN, 300 times; LOSS_CNT saturates.
        lc = 8'd2;
        for (int i = 0; i < 300; i++) begin
            lc = (lc == 8'hFF) ? lc : lc + 8'd1;
            expect_tr(3'd0, 2'd0, lc, 3, "E_loss");
            expect_tr(3'd1, 2'd0, lc, 4, "E_wait");
            expect_tr(3'd2, 2'd0, lc, 1, "E_stable");
            expect_tr(3'd3, 2'd0, lc, 8, "E_run");
            bus.MMCM_LOCKED = 1'b0;
            @(negedge clk);
            bus.MMCM_LOCKED = 1'b1;
            wait_leave(3'd3, 10, "E_leave_run");
            wait_state(3'd3, 40, "E_reach_run");
        end
        chk("E_loss_saturated", 32'(bus.LOSS_CNT), 32'd255);

        // Asynchronous reset while in STABLE.
        expect_tr(3'd0, 2'd0, 8'd255, 3, "F_loss");
        expect_tr(3'd1, 2'd0, 8'd255, 4, "F_wait");
        expect_tr(3'd2, 2'd0, 8'd255, 3, "F_stable");
        bus.MMCM_LOCKED = 1'b0;
        wait_state(3'd1, 40, "F_reach_wait");
        bus.MMCM_LOCKED = 1'b1;
        wait_state(3'd2, 10, "F_reach_stable");
        @(posedge clk); #2 RESET = 1'b1;
        #1 chk("F_async_reset", 32'(snap()), 32'(tup(3'd0, 2'd0, 8'd0)));
        expect_tr(3'd1, 2'd0, 8'd0, 4, "F_rehold");
        expect_tr(3'd2, 2'd0, 8'd0, 1, "F_restable");
        expect_tr(3'd3, 2'd0, 8'd0, 8, "F_rerun");
        @(posedge clk); #2 RESET = 1'b0;
        wait_state(3'd3, 40, "F_reach_run");

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
